mem_line_responder: RTL

Memory-side responder for cache line fills and dirty-line writebacks. It accepts one line-granular read or write request at a time from the cache miss path, waits a programmable access latency, and returns the fill data or a write acknowledge over a valid/ready response channel. It sits between the set-associative cache and the rest of the memory system, and it serves as the backing store in simulation and on FPGA.

---
 rtl/mem_line_responder.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mem_line_responder.sv
// mem_line_responder
//   Memory-side responder for cache line fills and dirty-line writebacks.
//   Accepts one line-granular request at a time, waits LATENCY cycles, then
//   performs the array access and returns fill data (or a write ack).
//
//   Build option: MEM_WRITE_ACK_EN
//     defined   - writes go through RESP and return resp_write=1, resp_data=0
//     undefined - writes commit on BUSY exit and return straight to IDLE;
//                 resp_write is tied to 0
//
// Ports
//   clk, reset             clock, asynchronous active-high reset
//   req_valid / req_ready  request handshake (ready only in IDLE)
//   req_write              1 = writeback, 0 = line fill
//   req_addr               byte address; line index = addr[IDX_HI:IDX_LO]
//   req_data, req_wmask    writeback data and per-word write enable
//   resp_valid/resp_ready  response handshake
//   resp_data, resp_write  fill data / write-ack flag
//
// state | meaning
// IDLE  | req_ready=1, waiting for a request
// BUSY  | latency countdown; access performed when counter hits 0
// RESP  | resp_valid=1, held until resp_ready
module mem_line_responder #(
  parameter int logWidth = 7,
  parameter int wordsize = 64,
  parameter int addrsize = 64,
  parameter int logLines = 10,
  parameter int LATENCY  = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_write,
  input  logic [addrsize-1:0]              req_addr,
  input  logic [(1<<logWidth)-1:0]         req_data,
  input  logic [(1<<logWidth)/wordsize-1:0] req_wmask,
  output logic                             resp_valid,
  input  logic                             resp_ready,
  output logic [(1<<logWidth)-1:0]         resp_data,
  output logic                             resp_write
);

  localparam int WIDTH  = 1 << logWidth;
  localparam int WORDS  = WIDTH / wordsize;
  localparam int LINES  = 1 << logLines;
  localparam int IDX_LO = logWidth - 3;
  localparam int IDX_HI = IDX_LO + logLines - 1;
  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t               state, state_next;
  logic [7:0]           cnt;
  logic                 lat_write;
  logic [logLines-1:0]  lat_idx;
  logic [WIDTH-1:0]     lat_data;
  logic [WORDS-1:0]     lat_mask;
  logic                 accept;
  logic                 done;

  // Zero at time zero; reset deliberately leaves the contents alone.
  logic [WIDTH-1:0] mem [LINES] = '{default: '0};

  // Offset and above-capacity address bits are ignored (wrap-around alias).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[addrsize-1:IDX_HI+1], req_addr[IDX_LO-1:0]};

  assign accept = (state == IDLE) && req_valid;
  assign done   = (state == BUSY) && (cnt == 8'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = BUSY;
      end
      BUSY: begin
        if (cnt == 8'd0) begin
`ifdef MEM_WRITE_ACK_EN
          state_next = RESP;
`else
          state_next = lat_write ? IDLE : RESP;
`endif
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= 8'd0;
      lat_write <= 1'b0;
      lat_idx   <= '0;
      lat_data  <= '0;
      lat_mask  <= '0;
      resp_data <= '0;
    end else begin
      if (accept) begin
        lat_write <= req_write;
        lat_idx   <= req_addr[IDX_HI:IDX_LO];
        lat_data  <= req_data;
        lat_mask  <= req_wmask;
        cnt       <= CNT_LOAD;
      end else if ((state == BUSY) && (cnt != 8'd0)) begin
        cnt <= cnt - 8'd1;
      end
      if (done) resp_data <= lat_write ? '0 : mem[lat_idx];
    end
  end

`ifdef MEM_WRITE_ACK_EN
  logic resp_write_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     resp_write_q <= 1'b0;
    else if (done) resp_write_q <= lat_write;
  end
  assign resp_write = resp_write_q;
`else
  assign resp_write = 1'b0;
`endif

  // A reset during BUSY clears state before done can fire, so an aborted
  // write never reaches the array.
  always_ff @(posedge clk) begin
    if (done && lat_write) begin
      for (int w = 0; w < WORDS; w++) begin
        if (lat_mask[w]) mem[lat_idx][w*wordsize +: wordsize] <= lat_data[w*wordsize +: wordsize];
      end
    end
  end

endmodule
